// File: rtl/secuenciador_booth.sv
// Operand sequencer for the Booth multiplier: FIFO-buffered operand pairs are issued one at a
// time, products are collected on a valid/ready port, and a watchdog flags multiplier hangs.
module secuenciador_booth #(
   parameter int PROF    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_a,
   input  logic [2:0] in_b,
   output logic [2:0] mul_multiplicador,
   output logic [2:0] mul_multiplicando,
   output logic       mul_start,
   input  logic [5:0] mul_resultado,
   input  logic       mul_fin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_resultado,
   output logic       err
);

   localparam int PW = $clog2(PROF);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [5:0]    r_mem [PROF];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_visto_bajo;
   logic [4:0]    r_wdog;
   logic [2:0]    r_mul_a;
   logic [2:0]    r_mul_b;
   logic          r_mul_start;
   logic          r_out_valid;
   logic [5:0]    r_out_res;
   logic          r_err;

   logic w_push;
   logic w_pop;
   logic w_recog;
   logic w_load;
   logic w_wdog_fire;
   logic w_out_free;

   assign in_ready          = (r_count != CW'(PROF));
   assign w_push            = in_valid & in_ready;
   assign w_out_free        = ~r_out_valid | out_ready;
   assign mul_multiplicador = r_mul_a;
   assign mul_multiplicando = r_mul_b;
   assign mul_start         = r_mul_start;
   assign out_valid         = r_out_valid;
   assign out_resultado     = r_out_res;
   assign err               = r_err;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_recog     = 1'b0;
      w_load      = 1'b0;
      w_wdog_fire = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_count != '0) begin
               w_pop  = 1'b1;
               w_next = ST_ISSUE;
            end
         end
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT: begin
            // A fin level seen before it has ever dropped belongs to the previous operation.
            w_recog = mul_fin & r_visto_bajo;
            if (w_recog) begin
               if (w_out_free) begin
                  w_load = 1'b1;
                  w_next = ST_IDLE;
               end else begin
                  w_next = ST_HOLD;
               end
            end else if (r_wdog == 5'(TIMEOUT - 1)) begin
               w_wdog_fire = 1'b1;
               w_next      = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (w_out_free) begin
               w_load = 1'b1;
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_visto_bajo <= 1'b0;
         r_wdog       <= '0;
         r_mul_a      <= '0;
         r_mul_b      <= '0;
         r_mul_start  <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_res    <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_mul_start <= w_pop;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         if (w_pop) {r_mul_a, r_mul_b} <= r_mem[r_rd_ptr];

         if (r_state == ST_ISSUE) begin
            r_visto_bajo <= 1'b0;
            r_wdog       <= '0;
         end else if (r_state == ST_WAIT) begin
            if (!mul_fin) r_visto_bajo <= 1'b1;
            if (!w_recog) r_wdog <= r_wdog + 1'b1;
         end

         // A load on the handshake edge keeps out_valid high with the new product.
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_res   <= mul_resultado;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_wdog_fire) r_err <= 1'b1;
      end
   end

   // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b};
   end

endmodule

// File: doc/secuenciador_booth.md
# secuenciador_booth

Operand sequencer upstream of the Booth multiplier. It buffers operand pairs from a producer in a small FIFO and issues them one at a time to the multiplier's `multiplicador`/`multiplicando`/`start` inputs. It collects `resultado` when `fin` rises, presents each product on a valid/ready output port, and flags multiplier hangs with a watchdog.

## Interface

Parameters
- PROF, 4: FIFO depth in operand pairs; power of two, ≥2.
- TIMEOUT, 15: maximum WAIT cycles before the watchdog fires; ≥1, fits in 5 bits.

Ports
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers an operand pair.
- in_ready  out  1  FIFO not full.
- in_a  in  3  multiplicador operand, two's complement.
- in_b  in  3  multiplicando operand, two's complement.
- mul_multiplicador  out  3  registered operand to the multiplier.
- mul_multiplicando  out  3  registered operand to the multiplier.
- mul_start  out  1  one-cycle start pulse.
- mul_resultado  in  6  multiplier product; stable while mul_fin=1.
- mul_fin  in  1  multiplier done; a level held until after the next start.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- out_resultado  out  6  product, two's complement.
- err  out  1  sticky watchdog flag.

## Operation

- FIFO: PROF entries of {a,b}, with a circular read/write pointer and a count register.
  - Push when in_valid & in_ready; in_ready = (count != PROF).
  - Pop is internal only.
  - Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if count>0, latch the FIFO head into mul_multiplicador/mul_multiplicando, pop, and go to ISSUE. Otherwise stay.
- ISSUE: mul_start=1 for exactly this cycle. Clear visto_bajo and the watchdog counter, then go to WAIT.
- WAIT: set visto_bajo when mul_fin=0.
  - A result is recognised only when mul_fin=1 and visto_bajo=1; this rejects the stale fin from the previous operation.
  - On recognition: if the output register is empty, or is being consumed this cycle (out_valid & out_ready), load out_resultado ← mul_resultado, set out_valid, and go to IDLE. Otherwise go to HOLD.
  - Watchdog: counts every WAIT cycle without recognition. When the counter reaches TIMEOUT: set err, discard the operation, go to IDLE.
- HOLD: the multiplier holds its result.
  - When the output register frees (out_valid=0, or out_ready=1 this cycle), load mul_resultado, set out_valid, and go to IDLE.
  - The watchdog is inactive in HOLD.
- Output register: out_valid stays high and out_resultado stays stable until out_valid & out_ready. It drops the cycle after the handshake unless it is reloaded in that same cycle.
- The 6-bit product is passed through unchanged; there is no sign extension or saturation.
- err: set only by the watchdog; cleared only by reset; does not stop operation.

## Timing

- Reset values:
  - in_ready=1, mul_start=0, mul_multiplicador=0, mul_multiplicando=0, out_valid=0, out_resultado=0, err=0.
  - FSM=IDLE, count=0, pointers=0, visto_bajo=0, watchdog=0.
- Reset mid-operation (any state) abandons the in-flight operation and empties the FIFO. The multiplier is not reset by this block.
- All outputs are registered; there are no combinational in→out paths. in_ready depends only on count.
- Latency, empty FIFO and IDLE: push at edge T → pop/latch at edge T+1 → mul_start high between edges T+1 and T+2.
- Result recognised at edge E with the output register free → out_valid high after E.
- Issue rate: at most one start per multiplication. The next start is ≥2 cycles after result capture (IDLE→ISSUE).
- Full FIFO: in_ready=0 in the cycle after the PROF-th push. It rises in the cycle after the first pop.
- Pointers wrap modulo PROF.
- Simultaneous out_ready handshake and new result in WAIT or HOLD: the old product is consumed and the new one is loaded on the same edge, so out_valid stays high.

## Test plan

- Single op, with the real multiplier attached: in_a=3, in_b=6 (−2) → exactly one mul_start pulse; out_resultado=6'b111010 (−6); out_valid held until out_ready; err=0.
- Burst with PROF=4: push (1,1), (2,3), (−4,−4), (3,−1) back-to-back, then a 5th pair → in_ready=0 while full, 5th accepted after the first pop. Outputs in order: 1, 6, 16, −3, then the 5th product.
- Back-pressure: out_ready=0 for 40 cycles with 2 ops queued → first product held stable, FSM parks in HOLD, no third start. Raising out_ready releases both products in order.
- Stale-fin rejection: behavioural multiplier keeps fin=1 for 3 cycles after start before dropping → no early capture; the captured value is the new product.
- Watchdog: behavioural multiplier never asserts fin after start → err=1 exactly TIMEOUT cycles into WAIT, no out_valid; next queued op still issues.
- Reset in WAIT with 2 ops queued → all reset values next cycle, no out_valid, no further start until a new push.
